// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
`ifndef INST_ADDR_BUS
`define INST_ADDR_BUS 31:0
`endif
`ifndef INST_DATA_BUS
`define INST_DATA_BUS 31:0
`endif

package ifu_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_OUT  = 3'd3,
    S_WAIT = 3'd4
  } ifu_state_t;

  localparam logic [31:0] RESET_PC      = 32'h8000_0000;
  localparam logic [31:0] INST_NOP      = 32'h0000_0013;
  localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/ifu_if.sv
// Fetch-side bus bundle: AXI4-Lite read channel to instruction memory,
// valid/ready toward decode, and the npc return path from writeback.
interface ifu_if;
  logic [`INST_ADDR_BUS] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [`INST_DATA_BUS] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  logic [`INST_DATA_BUS] inst;
  logic [`INST_ADDR_BUS] pc;
  logic                  this_valid;
  logic                  next_ready;
  logic                  wb_valid;
  logic [`INST_ADDR_BUS] npc;
  logic                  this_ready;
  logic                  fetch_err;

  // The ifu side drives the address/handshake outputs.
  modport master (
    output araddr, arvalid, rready, inst, pc, this_valid, this_ready, fetch_err,
    input  arready, rdata, rresp, rvalid, next_ready, wb_valid, npc
  );

  // Memory / decode / writeback side.
  modport slave (
    input  araddr, arvalid, rready, inst, pc, this_valid, this_ready, fetch_err,
    output arready, rdata, rresp, rvalid, next_ready, wb_valid, npc
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: holds the PC, fetches one instruction over AXI4-Lite,
// hands it to decode, then waits for writeback to supply the next PC.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ifu_pkg::RESET_PC
) (
  input  logic  clk,
  input  logic  rst,
  ifu_if.master bus
);

  ifu_state_t state, state_nxt;

  logic [`INST_ADDR_BUS] pc_q;
  logic [`INST_DATA_BUS] inst_q;
  logic                  err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_nxt          = state;
    bus.arvalid        = 1'b0;
    bus.rready         = 1'b0;
    bus.this_valid     = 1'b0;
    bus.this_ready     = 1'b0;
    unique case (state)
      S_IDLE: state_nxt = S_AR;
      S_AR: begin
        bus.arvalid = 1'b1;
        if (bus.arready) state_nxt = S_R;
      end
      S_R: begin
        bus.rready = 1'b1;
        if (bus.rvalid) state_nxt = S_OUT;
      end
      S_OUT: begin
        bus.this_valid = 1'b1;
        if (bus.next_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        bus.this_ready = 1'b1;
        if (bus.wb_valid) state_nxt = S_AR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // PC, instruction and error-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      inst_q <= INST_NOP;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state == S_R && bus.rvalid) begin
        inst_q <= bus.rdata;
        err_q  <= (bus.rresp != AXI_RESP_OKAY);
      end
      if (state == S_WAIT && bus.wb_valid)
        pc_q <= {bus.npc[31:2], 2'b00};
    end
  end

  // Registered values straight to the bus.
  always_comb begin
    bus.araddr    = pc_q;
    bus.pc        = pc_q;
    bus.inst      = inst_q;
    bus.fetch_err = err_q;
  end

endmodule
